sample6_sched_ctrl: RTL and testbench

- Hard-wired schedule controller for the sample6 datapath, which has one ALU (alu1), one MUL (mul1), one LOG (log1) and ten intermediate registers.
- Sequences an 8-step list schedule that computes one result from i1/i2/i3. It drives every mux select, op code and register enable, plus done_next and result_en.
- Sits between the top-level start/busy handshake and the datapath control inputs.

---
 rtl/sample6_sched_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sample6_sched_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample6_sched_ctrl.sv
// Hard-wired 8-step list-schedule controller for the sample6 datapath (alu1, mul1, log1).
// Moore decode of state plus a stall qualifier that freezes the step and masks all writes.
module sample6_sched_ctrl #(
    parameter int SEL_W = 4,
    parameter int STW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic [SEL_W-1:0] alu1_sel1,
    output logic [SEL_W-1:0] alu1_sel2,
    output logic [SEL_W-1:0] log1_sel1,
    output logic [SEL_W-1:0] log1_sel2,
    output logic [SEL_W-1:0] mul1_sel1,
    output logic [SEL_W-1:0] mul1_sel2,
    output logic             alu1_op,
    output logic [1:0]       log1_op,
    output logic             mul1_op,
    output logic             reg_alu0_en,
    output logic             reg_alu1_en,
    output logic             reg_alu3_en,
    output logic             reg_alu7_en,
    output logic             reg_alu8_en,
    output logic             reg_alu9_en,
    output logic             reg_log2_en,
    output logic             reg_log6_en,
    output logic             reg_mul4_en,
    output logic             reg_mul5_en,
    output logic             result_en,
    output logic             done_next
);

    typedef enum logic [STW-1:0] {IDLE, S1, S2, S3, S4, S5, S6, S7, S8} state_t;

    localparam logic [SEL_W-1:0] SEL_I1   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_I2   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_I3   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_ALU0 = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_ALU1 = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_LOG2 = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_ALU3 = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_MUL4 = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_MUL5 = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_LOG6 = SEL_W'(9);
    localparam logic [SEL_W-1:0] SEL_ALU7 = SEL_W'(10);
    localparam logic [SEL_W-1:0] SEL_ALU8 = SEL_W'(11);
    localparam logic [SEL_W-1:0] SEL_ALU9 = SEL_W'(12);

    localparam logic       ALU_ADD = 1'b0;
    localparam logic       ALU_SUB = 1'b1;
    localparam logic [1:0] LOG_AND = 2'b00;
    localparam logic [1:0] LOG_XOR = 2'b10;
    localparam logic       MUL_MUL = 1'b0;

    state_t state, state_next;
    logic   wr;

    // A stalled step keeps its operand routing but must not commit anything.
    assign wr = ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = IDLE;
        busy        = 1'b0;
        alu1_sel1   = '0;
        alu1_sel2   = '0;
        log1_sel1   = '0;
        log1_sel2   = '0;
        mul1_sel1   = '0;
        mul1_sel2   = '0;
        alu1_op     = ALU_ADD;
        log1_op     = LOG_AND;
        mul1_op     = MUL_MUL;
        reg_alu0_en = 1'b0;
        reg_alu1_en = 1'b0;
        reg_alu3_en = 1'b0;
        reg_alu7_en = 1'b0;
        reg_alu8_en = 1'b0;
        reg_alu9_en = 1'b0;
        reg_log2_en = 1'b0;
        reg_log6_en = 1'b0;
        reg_mul4_en = 1'b0;
        reg_mul5_en = 1'b0;
        result_en   = 1'b0;
        done_next   = 1'b0;

        case (state)
            IDLE: state_next = start ? S1 : IDLE;
            S1: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_I1;
                alu1_sel2   = SEL_I2;
                reg_alu0_en = wr;
                log1_sel1   = SEL_I1;
                log1_sel2   = SEL_I3;
                log1_op     = LOG_AND;
                reg_log2_en = wr;
                state_next  = stall ? S1 : S2;
            end
            S2: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_I2;
                alu1_sel2   = SEL_I3;
                alu1_op     = ALU_SUB;
                reg_alu1_en = wr;
                mul1_sel1   = SEL_LOG2;
                mul1_sel2   = SEL_I1;
                mul1_op     = MUL_MUL;
                reg_mul4_en = wr;
                state_next  = stall ? S2 : S3;
            end
            S3: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_ALU0;
                alu1_sel2   = SEL_ALU1;
                reg_alu3_en = wr;
                log1_sel1   = SEL_MUL4;
                log1_sel2   = SEL_ALU1;
                log1_op     = LOG_XOR;
                reg_log6_en = wr;
                state_next  = stall ? S3 : S4;
            end
            S4: begin
                busy        = 1'b1;
                mul1_sel1   = SEL_ALU3;
                mul1_sel2   = SEL_I2;
                reg_mul5_en = wr;
                state_next  = stall ? S4 : S5;
            end
            S5: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_MUL5;
                alu1_sel2   = SEL_LOG6;
                reg_alu7_en = wr;
                state_next  = stall ? S5 : S6;
            end
            S6: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_ALU7;
                alu1_sel2   = SEL_I3;
                alu1_op     = ALU_SUB;
                reg_alu8_en = wr;
                state_next  = stall ? S6 : S7;
            end
            S7: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_ALU8;
                alu1_sel2   = SEL_ALU0;
                reg_alu9_en = wr;
                state_next  = stall ? S7 : S8;
            end
            S8: begin
                busy        = 1'b1;
                alu1_sel1   = SEL_ALU9;
                alu1_sel2   = SEL_LOG2;
                alu1_op     = ALU_SUB;
                result_en   = wr;
                done_next   = wr;
                // A start seen in the final step chains straight into the next run.
                if (stall)      state_next = S8;
                else if (start) state_next = S1;
                else            state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample6_sched_ctrl.sv
// Bench for sample6_sched_ctrl: schedule-table reference model plus a small datapath
// driven by the controller, checked against the closed-form arithmetic of the schedule.
module tb_sample6_sched_ctrl;

    logic       clk, rst, start, stall;
    logic       busy;
    logic [3:0] alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2;
    logic       alu1_op, mul1_op;
    logic [1:0] log1_op;
    logic       reg_alu0_en, reg_alu1_en, reg_alu3_en, reg_alu7_en, reg_alu8_en, reg_alu9_en;
    logic       reg_log2_en, reg_log6_en, reg_mul4_en, reg_mul5_en, result_en, done_next;

    sample6_sched_ctrl #(.SEL_W(4), .STW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy),
        .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2),
        .log1_sel1(log1_sel1), .log1_sel2(log1_sel2),
        .mul1_sel1(mul1_sel1), .mul1_sel2(mul1_sel2),
        .alu1_op(alu1_op), .log1_op(log1_op), .mul1_op(mul1_op),
        .reg_alu0_en(reg_alu0_en), .reg_alu1_en(reg_alu1_en), .reg_alu3_en(reg_alu3_en),
        .reg_alu7_en(reg_alu7_en), .reg_alu8_en(reg_alu8_en), .reg_alu9_en(reg_alu9_en),
        .reg_log2_en(reg_log2_en), .reg_log6_en(reg_log6_en),
        .reg_mul4_en(reg_mul4_en), .reg_mul5_en(reg_mul5_en),
        .result_en(result_en), .done_next(done_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed control word, in a fixed order shared with the model.
    logic [40:0] obs;
    assign obs = {busy, alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2,
                  alu1_op, log1_op, mul1_op,
                  reg_alu0_en, reg_alu1_en, reg_alu3_en, reg_alu7_en, reg_alu8_en,
                  reg_alu9_en, reg_log2_en, reg_log6_en, reg_mul4_en, reg_mul5_en,
                  result_en, done_next};

    // Schedule table rows per step 0..8: {sel1, sel2, op, dest code}; dest -1 = unit idle,
    // dest 13 = result register. Dest codes reuse the select encoding of that register.
    int alu_tab [0:8][0:3] = '{'{0,0,0,-1}, '{0,1,0,3},  '{1,2,1,4},  '{3,4,0,6}, '{0,0,0,-1},
                              '{8,9,0,10}, '{10,2,1,11}, '{11,3,0,12}, '{12,5,1,13}};
    int log_tab [0:8][0:3] = '{'{0,0,0,-1}, '{0,2,0,5},  '{0,0,0,-1}, '{7,4,2,9}, '{0,0,0,-1},
                              '{0,0,0,-1}, '{0,0,0,-1}, '{0,0,0,-1}, '{0,0,0,-1}};
    int mul_tab [0:8][0:3] = '{'{0,0,0,-1}, '{0,0,0,-1}, '{5,0,0,7},  '{0,0,0,-1}, '{6,1,0,8},
                              '{0,0,0,-1}, '{0,0,0,-1}, '{0,0,0,-1}, '{0,0,0,-1}};

    function automatic logic [40:0] model_out(input int s, input bit sl);
        logic [13:0] wr;
        wr = '0;
        if (!sl) begin
            if (alu_tab[s][3] >= 0) wr[alu_tab[s][3]] = 1'b1;
            if (log_tab[s][3] >= 0) wr[log_tab[s][3]] = 1'b1;
            if (mul_tab[s][3] >= 0) wr[mul_tab[s][3]] = 1'b1;
        end
        return {(s != 0),
                4'(alu_tab[s][0]), 4'(alu_tab[s][1]), 4'(log_tab[s][0]), 4'(log_tab[s][1]),
                4'(mul_tab[s][0]), 4'(mul_tab[s][1]),
                1'(alu_tab[s][2]), 2'(log_tab[s][2]), 1'(mul_tab[s][2]),
                wr[3], wr[4], wr[6], wr[10], wr[11], wr[12], wr[5], wr[9], wr[7], wr[8],
                wr[13], wr[13]};
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, b, c);
        logic [31:0] alu0, log2, alu1, mul4, alu3, log6, mul5, alu7, alu8, alu9;
        alu0 = a + b;     log2 = a & c;     alu1 = b - c;     mul4 = log2 * a;
        alu3 = alu0 + alu1; log6 = mul4 ^ alu1; mul5 = alu3 * b; alu7 = mul5 + log6;
        alu8 = alu7 - c;  alu9 = alu8 + alu0;
        return alu9 - log2;
    endfunction

    // Datapath stand-in: register file indexed by the select encoding.
    logic [31:0] i1, i2, i3;
    logic [31:0] rg [3:13];
    logic        dp_done;
    logic [31:0] alu_a, alu_b, log_a, log_b, mul_a, mul_b, alu_y, log_y, mul_y;

    function automatic logic [31:0] pick(input logic [3:0] s);
        if (s == 4'd0)       return i1;
        else if (s == 4'd1)  return i2;
        else if (s == 4'd2)  return i3;
        else if (s <= 4'd12) return rg[s];
        else                 return 32'd0;
    endfunction

    always_comb begin
        alu_a = pick(alu1_sel1);
        alu_b = pick(alu1_sel2);
        log_a = pick(log1_sel1);
        log_b = pick(log1_sel2);
        mul_a = pick(mul1_sel1);
        mul_b = pick(mul1_sel2);
        alu_y = alu1_op ? alu_a - alu_b : alu_a + alu_b;
        case (log1_op)
            2'b00:   log_y = log_a & log_b;
            2'b01:   log_y = log_a | log_b;
            2'b10:   log_y = log_a ^ log_b;
            default: log_y = 32'd0;
        endcase
        mul_y = mul1_op ? ((mul_b != 0) ? mul_a / mul_b : 32'd0) : mul_a * mul_b;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_done <= 1'b0;
        end else begin
            dp_done <= done_next;
            if (reg_alu0_en) rg[3]  <= alu_y;
            if (reg_alu1_en) rg[4]  <= alu_y;
            if (reg_log2_en) rg[5]  <= log_y;
            if (reg_alu3_en) rg[6]  <= alu_y;
            if (reg_mul4_en) rg[7]  <= mul_y;
            if (reg_mul5_en) rg[8]  <= mul_y;
            if (reg_log6_en) rg[9]  <= log_y;
            if (reg_alu7_en) rg[10] <= alu_y;
            if (reg_alu8_en) rg[11] <= alu_y;
            if (reg_alu9_en) rg[12] <= alu_y;
            if (result_en)   rg[13] <= alu_y;
        end
    end

    int step = 0;
    bit exp_done = 1'b0;
    int runs_done = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One clock: drive, check control word and done, advance model, check result on completion.
    task automatic cycle(input bit st, input bit sl);
        logic [40:0] e;
        bit finishing;
        @(negedge clk);
        start = st;
        stall = sl;
        #1;
        e = model_out(step, sl);
        chk($sformatf("ctrl_s%0d_st%0d_sl%0d", step, st, sl), 64'(obs), 64'(e));
        chk("done", 64'(dp_done), 64'(exp_done));
        @(posedge clk);
        exp_done  = e[0];
        finishing = (step == 8) && !sl;
        if (step == 0)       step = st ? 1 : 0;
        else if (sl)         step = step;
        else if (step < 8)   step = step + 1;
        else                 step = st ? 1 : 0;
        #1;
        if (finishing) begin
            runs_done++;
            chk("result", 64'(rg[13]), 64'(ref_result(i1, i2, i3)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        i1 = 32'd5; i2 = 32'd3; i3 = 32'd2;
        #1;
        chk("reset_ctrl", 64'(obs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of S4.
        cycle(1, 0);
        repeat (3) cycle(0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", 64'(obs), 64'd0);
        step = 0;
        exp_done = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_ctrl", 64'(obs), 64'd0);
        chk("rst_no_done", 64'(dp_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain run, 5/3/2.
        cycle(1, 0);
        repeat (8) cycle(0, 0);
        chk("result_5_3_2", 64'(rg[13]), 64'd34);
        cycle(0, 0);

        // Plain run, 12/7/6; stall in IDLE with start still launches.
        i1 = 32'd12; i2 = 32'd7; i3 = 32'd6;
        cycle(1, 1);
        repeat (8) cycle(0, 0);
        chk("result_12_7_6", 64'(rg[13]), 64'd198);
        cycle(0, 0);

        // Three stall cycles in S5.
        i1 = 32'd5; i2 = 32'd3; i3 = 32'd2;
        cycle(1, 0);
        repeat (4) cycle(0, 0);
        repeat (3) cycle(0, 1);
        repeat (4) cycle(0, 0);
        chk("result_stalled", 64'(rg[13]), 64'd34);
        cycle(0, 0);

        // start held high: back-to-back runs, no restart mid-run.
        i1 = 32'd9; i2 = 32'd4; i3 = 32'd11;
        runs_done = 0;
        repeat (25) cycle(1, 0);
        chk("b2b_runs", 64'(runs_done), 64'd3);
        repeat (9) cycle(0, 0);

        // Random start/stall traffic; operands change only while idle.
        repeat (300) begin
            if (step == 0) begin
                i1 = $urandom_range(0, 255);
                i2 = $urandom_range(0, 255);
                i3 = $urandom_range(0, 255);
            end
            cycle(($urandom % 3) == 0, ($urandom % 4) == 0);
        end
        repeat (12) cycle(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
